brnfck_out_fifo: RTL and testbench
==================================

Name: brnfck_out_fifo

Overview:
- Output buffer directly downstream of the processor control/data path.
- Accepts each byte the processor emits on its `.` instruction through the out_valid/out_ack handshake, stores it in a small FIFO, and drains it to an external byte sink through a valid/ready interface.
- Decouples program execution from a slow consumer. The processor stalls in its WRITE state only when the FIFO is full.

Parameters:
- DEPTH, 8, FIFO entries; power of two, >= 2.
- CNT_W, 16, width of the emitted-byte counter.

Ports:
- clk  in  1  system clock, all state on rising edge.
- nrst  in  1  reset, synchronous, active-low.
- clear  in  1  synchronous flush of FIFO contents and counter (pulsed by top level on program start).
- out_valid  in  1  processor presents a byte (WRITE state).
- out_data  in  8  byte from datapath (current cell value); valid while out_valid=1.
- out_ack  out  1  byte accepted this cycle; processor advances PC in the same cycle.
- tx_valid  out  1  FIFO head byte available to sink.
- tx_data  out  8  FIFO head byte.
- tx_ready  in  1  sink accepts head byte this cycle.
- level  out  $clog2(DEPTH)+1  current occupancy, 0..DEPTH.
- full  out  1  level == DEPTH.
- empty  out  1  level == 0.
- byte_count  out  CNT_W  total bytes accepted since reset/clear; wraps modulo 2^CNT_W.

Behaviour:
- Reset (nrst=0 at a clock edge): rd_ptr=wr_ptr=0, level=0, byte_count=0.
  - While nrst=0: out_ack=0, tx_valid=0, tx_data=0, full=0, empty=1.
  - Storage RAM is not reset.
  - Reset mid-transfer discards all buffered bytes; no partial handshake survives.
- out_ack:
  - Combinational: out_ack = nrst & !clear & !full. It is independent of out_valid and tx_ready, so there is no combinational path from tx_ready to out_ack.
  - Push occurs when out_valid & out_ack. At that edge: mem[wr_ptr] <= out_data, wr_ptr++ (mod DEPTH), byte_count++.
  - Handshake is single-cycle. The processor leaves WRITE the same cycle out_ack=1, so the FIFO must capture out_data in that cycle.
- tx side:
  - tx_valid = !empty & nrst; tx_data = mem[rd_ptr] (0 when empty).
  - Pop occurs when tx_valid & tx_ready: rd_ptr++ (mod DEPTH).
  - tx_data must hold stable while tx_valid=1 and tx_ready=0.
- Latency: a byte pushed at edge N is visible on tx_valid/tx_data after edge N. There is no fall-through bypass when empty.
- Occupancy updates:
  - Push only: level+1.
  - Pop only: level-1.
  - Push and pop in the same cycle: level unchanged, both pointers advance.
- Full: out_ack=0, and the processor waits in WRITE. A pop in that cycle does not enable a push in the same cycle; the push is accepted next cycle.
- Empty: tx_valid=0; tx_ready is ignored.
- Pointer wrap: pointers are log2(DEPTH) bits and wrap naturally. full/empty derive from level, not from pointer equality.
- clear=1 (with nrst=1):
  - Takes priority over push and pop: pointers, level and byte_count go to 0 next edge.
  - out_ack=0 during clear, so no byte is lost mid-handshake.
  - tx_valid may still be 1 in the clear cycle; a pop in that cycle is discarded.
- byte_count: increments on every push, wraps from 2^CNT_W-1 to 0, unaffected by pops.
- No assertion of out_ack occurs without a corresponding write. Overflow and underflow are impossible by construction.

Test Plan:
- Reset: hold nrst=0 for 2 cycles with out_valid=1, out_data=8'h41 -> out_ack=0, tx_valid=0, level=0, byte_count=0. After release: out_ack=1 and 'A' is pushed on the first edge.
- Basic stream: push 8'h48, 8'h69 ("Hi") with tx_ready=1 -> tx_data=8'h48 one cycle after push, then 8'h69. byte_count=2, level returns to 0.
- Fill and stall: tx_ready=0, push 9 bytes 8'h00..8'h08 with DEPTH=8 -> out_ack=1 for 8 bytes, then full=1, out_ack=0 and the 9th byte is held. Raise tx_ready for one cycle -> 8'h00 popped; 8'h08 accepted on the following cycle; drain order 00..08.
- Simultaneous push/pop at level=4 -> level stays 4 and both pointers advance. Run 20 such cycles to cross pointer wrap; output order matches input order.
- Clear mid-stream: level=5, byte_count=5, assert clear with out_valid=1 -> out_ack=0 during clear. Next cycle level=0, empty=1, tx_valid=0, byte_count=0.
- Counter wrap with CNT_W=4: push 17 bytes -> byte_count reads 1.

Source files
------------

// File: rtl/brnfck_out_fifo.sv
// brnfck_out_fifo
// Output byte buffer between the processor's `.` instruction and an
// external byte sink. Bytes are accepted with a single-cycle
// out_valid/out_ack handshake, queued in a small FIFO, and drained on a
// valid/ready interface. The processor stalls in its WRITE state only
// when the FIFO is full.
//
// Ports:
//   clk         system clock; all state changes on the rising edge
//   nrst        synchronous active-low reset
//   clear       synchronous flush of FIFO contents and byte counter
//   out_valid   processor presents a byte
//   out_data    byte from the datapath, valid while out_valid=1
//   out_ack     byte accepted this cycle (processor advances its PC)
//   tx_valid    FIFO head byte available to the sink
//   tx_data     FIFO head byte (0 when nothing is available)
//   tx_ready    sink accepts the head byte this cycle
//   level       current occupancy, 0..DEPTH
//   full        level == DEPTH
//   empty       level == 0
//   byte_count  bytes accepted since reset/clear, wraps modulo 2^CNT_W

module brnfck_out_fifo #(
  parameter int DEPTH = 8,
  parameter int CNT_W = 16
) (
  input  logic                     clk,
  input  logic                     nrst,
  input  logic                     clear,
  input  logic                     out_valid,
  input  logic [7:0]               out_data,
  output logic                     out_ack,
  output logic                     tx_valid,
  output logic [7:0]               tx_data,
  input  logic                     tx_ready,
  output logic [$clog2(DEPTH):0]   level,
  output logic                     full,
  output logic                     empty,
  output logic [CNT_W-1:0]         byte_count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int LVL_W = PTR_W + 1;

  logic [7:0]       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [LVL_W-1:0] level_q;
  logic             push;
  logic             pop;

  // Status flags come from the occupancy counter rather than pointer
  // equality. They are gated with nrst so the outputs look idle for the
  // whole time reset is held, even before the first reset edge.
  assign full  = nrst && (level_q == LVL_W'(DEPTH));
  assign empty = !nrst || (level_q == '0);
  assign level = level_q;

  // out_ack deliberately ignores out_valid and tx_ready. This leaves no
  // combinational path from the sink back to the processor, and it means
  // a pop in a full cycle frees a slot only for the following cycle.
  assign out_ack  = nrst && !clear && !full;
  assign tx_valid = !empty;
  assign tx_data  = tx_valid ? mem[rd_ptr] : 8'h00;

  assign push = out_valid && out_ack;
  // A pop that coincides with clear is dropped along with the contents.
  assign pop  = tx_valid && tx_ready && !clear;

  // Storage is not reset. Only locations behind the occupancy count are
  // ever presented on tx_data.
  always_ff @(posedge clk) begin
    if (push) begin
      mem[wr_ptr] <= out_data;
    end
  end

  always_ff @(posedge clk) begin
    if (!nrst || clear) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      level_q    <= '0;
      byte_count <= '0;
    end else begin
      // The pointers are exactly log2(DEPTH) bits wide, so they wrap
      // naturally.
      if (push) begin
        wr_ptr     <= wr_ptr + PTR_W'(1);
        byte_count <= byte_count + CNT_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      case ({push, pop})
        2'b10:   level_q <= level_q + LVL_W'(1);
        2'b01:   level_q <= level_q - LVL_W'(1);
        default: level_q <= level_q;
      endcase
    end
  end

endmodule

// File: tb/tb_brnfck_out_fifo.sv
// tb_brnfck_out_fifo
// Directed bench for brnfck_out_fifo. The stimulus side pushes every
// byte it offers into an expected-byte queue. A separate monitor pops
// that queue on each tx handshake and compares it against tx_data.
// Status outputs are checked at specific points against hand-computed
// values. A second instance with a 4-bit counter covers counter wrap.

module tb_brnfck_out_fifo;

  logic       clk = 1'b0;
  logic       nrst;
  logic       clear;
  logic       out_valid;
  logic [7:0] out_data;
  logic       out_ack;
  logic       tx_valid;
  logic [7:0] tx_data;
  logic       tx_ready;
  logic [3:0] level;
  logic       full;
  logic       empty;
  logic [15:0] byte_count;

  // Second instance, CNT_W=4, used only for the counter-wrap test.
  logic       clear2 = 1'b0;
  logic       out_valid2;
  logic [7:0] out_data2;
  logic       out_ack2;
  logic       tx_valid2;
  logic [7:0] tx_data2;
  logic       tx_ready2 = 1'b1;
  logic [3:0] level2;
  logic       full2;
  logic       empty2;
  logic [3:0] byte_count2;

  int total = 0;
  int bad   = 0;
  logic [7:0] exp_q [$];

  always #5 clk = ~clk;

  brnfck_out_fifo #(.DEPTH(8), .CNT_W(16)) dut (
    .clk(clk), .nrst(nrst), .clear(clear),
    .out_valid(out_valid), .out_data(out_data), .out_ack(out_ack),
    .tx_valid(tx_valid), .tx_data(tx_data), .tx_ready(tx_ready),
    .level(level), .full(full), .empty(empty), .byte_count(byte_count)
  );

  brnfck_out_fifo #(.DEPTH(8), .CNT_W(4)) dut_wrap (
    .clk(clk), .nrst(nrst), .clear(clear2),
    .out_valid(out_valid2), .out_data(out_data2), .out_ack(out_ack2),
    .tx_valid(tx_valid2), .tx_data(tx_data2), .tx_ready(tx_ready2),
    .level(level2), .full(full2), .empty(empty2), .byte_count(byte_count2)
  );

  task automatic check_output(input string name, input logic [31:0] act,
                              input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Every task starts and ends one time unit after a rising edge.
  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  // Offers one byte and waits, with a bound, for it to be acknowledged.
  task automatic apply_stimulus(input logic [7:0] b);
    bit got = 1'b0;
    out_valid = 1'b1;
    out_data  = b;
    exp_q.push_back(b);
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (out_ack) begin
        got = 1'b1;
        break;
      end
    end
    if (!got) begin
      total++;
      bad++;
      $display("[TB] FAIL push_timeout: byte %0h got no ack, expected ack within 40 cycles", b);
    end
    next_cycle();
    out_valid = 1'b0;
  endtask

  task automatic do_clear();
    clear = 1'b1;
    next_cycle();
    clear = 1'b0;
    exp_q.delete();
  endtask

  task automatic drain(input string name);
    tx_ready = 1'b1;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      if (empty) break;
    end
    check_output({name, "_empty"}, 32'(empty), 32'd1);
    check_output({name, "_queue_left"}, 32'(exp_q.size()), 32'd0);
    next_cycle();
    tx_ready = 1'b0;
  endtask

  // Monitor: compares each byte the sink takes against the queue head.
  initial begin
    logic [7:0] e;
    forever begin
      @(negedge clk);
      if (nrst && !clear && tx_valid && tx_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("[TB] FAIL tx_unexpected: got %0h, expected no byte", tx_data);
        end else begin
          e = exp_q.pop_front();
          if (tx_data !== e) begin
            bad++;
            $display("[TB] FAIL tx_data: got %0h, expected %0h", tx_data, e);
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got no end of test, expected end within 200000 time units");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int n;
    nrst       = 1'b0;
    clear      = 1'b0;
    out_valid  = 1'b1;
    out_data   = 8'h41;
    tx_ready   = 1'b0;
    out_valid2 = 1'b0;
    out_data2  = 8'h00;

    // Reset held for two edges while a byte is offered.
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_output("rst_out_ack", 32'(out_ack), 32'd0);
    check_output("rst_tx_valid", 32'(tx_valid), 32'd0);
    check_output("rst_tx_data", 32'(tx_data), 32'h0);
    check_output("rst_level", 32'(level), 32'd0);
    check_output("rst_byte_count", 32'(byte_count), 32'd0);
    check_output("rst_empty", 32'(empty), 32'd1);
    check_output("rst_full", 32'(full), 32'd0);

    // Release reset: 'A' is accepted on the first edge.
    next_cycle();
    nrst = 1'b1;
    exp_q.push_back(8'h41);
    @(negedge clk);
    check_output("rel_out_ack", 32'(out_ack), 32'd1);
    next_cycle();
    out_valid = 1'b0;
    @(negedge clk);
    check_output("rel_tx_valid", 32'(tx_valid), 32'd1);
    check_output("rel_tx_data", 32'(tx_data), 32'h41);
    check_output("rel_byte_count", 32'(byte_count), 32'd1);
    next_cycle();
    drain("rel");

    // Basic stream "Hi" with the sink always ready.
    do_clear();
    tx_ready  = 1'b1;
    out_valid = 1'b1;
    out_data  = 8'h48;
    exp_q.push_back(8'h48);
    @(negedge clk);
    check_output("hi_ack0", 32'(out_ack), 32'd1);
    check_output("hi_no_bypass", 32'(tx_valid), 32'd0);
    next_cycle();
    out_data = 8'h69;
    exp_q.push_back(8'h69);
    @(negedge clk);
    check_output("hi_head_48", 32'(tx_data), 32'h48);
    check_output("hi_level_a", 32'(level), 32'd1);
    next_cycle();
    out_valid = 1'b0;
    @(negedge clk);
    check_output("hi_head_69", 32'(tx_data), 32'h69);
    check_output("hi_level_b", 32'(level), 32'd1);
    next_cycle();
    @(negedge clk);
    check_output("hi_level_end", 32'(level), 32'd0);
    check_output("hi_byte_count", 32'(byte_count), 32'd2);
    next_cycle();
    tx_ready = 1'b0;

    // Fill and stall: eight bytes fill the FIFO, the ninth waits.
    do_clear();
    for (int i = 0; i < 8; i++) apply_stimulus(8'(i));
    @(negedge clk);
    check_output("fill_full", 32'(full), 32'd1);
    check_output("fill_level", 32'(level), 32'd8);
    check_output("fill_ack", 32'(out_ack), 32'd0);
    next_cycle();
    out_valid = 1'b1;
    out_data  = 8'h08;
    exp_q.push_back(8'h08);
    @(negedge clk);
    check_output("stall_ack", 32'(out_ack), 32'd0);
    next_cycle();
    tx_ready = 1'b1;
    @(negedge clk);
    check_output("stall_ack_on_pop", 32'(out_ack), 32'd0);
    next_cycle();
    tx_ready = 1'b0;
    @(negedge clk);
    check_output("stall_ack_after_pop", 32'(out_ack), 32'd1);
    check_output("stall_level7", 32'(level), 32'd7);
    next_cycle();
    out_valid = 1'b0;
    @(negedge clk);
    check_output("stall_refull", 32'(full), 32'd1);
    next_cycle();
    drain("fill");

    // Simultaneous push/pop at level 4, crossing the pointer wrap.
    do_clear();
    for (int i = 0; i < 4; i++) apply_stimulus(8'h10 + 8'(i));
    tx_ready = 1'b1;
    for (int i = 0; i < 20; i++) begin
      out_valid = 1'b1;
      out_data  = 8'h20 + 8'(i);
      exp_q.push_back(out_data);
      @(negedge clk);
      check_output($sformatf("pp_level_%0d", i), 32'(level), 32'd4);
      next_cycle();
    end
    out_valid = 1'b0;
    tx_ready  = 1'b0;
    check_output("pp_byte_count", 32'(byte_count), 32'd24);
    drain("pp");

    // Clear mid-stream with a byte being offered.
    do_clear();
    for (int i = 0; i < 5; i++) apply_stimulus(8'h50 + 8'(i));
    @(negedge clk);
    check_output("clr_level5", 32'(level), 32'd5);
    check_output("clr_count5", 32'(byte_count), 32'd5);
    next_cycle();
    clear     = 1'b1;
    out_valid = 1'b1;
    out_data  = 8'hAA;
    @(negedge clk);
    check_output("clr_ack", 32'(out_ack), 32'd0);
    next_cycle();
    clear     = 1'b0;
    out_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    check_output("clr_level", 32'(level), 32'd0);
    check_output("clr_empty", 32'(empty), 32'd1);
    check_output("clr_tx_valid", 32'(tx_valid), 32'd0);
    check_output("clr_byte_count", 32'(byte_count), 32'd0);
    next_cycle();

    // Counter wrap on the 4-bit instance: 17 accepted bytes read as 1.
    out_valid2 = 1'b1;
    n = 0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (out_ack2) n++;
      if (n == 17) break;
      next_cycle();
      out_data2 = out_data2 + 8'd1;
    end
    next_cycle();
    out_valid2 = 1'b0;
    @(negedge clk);
    check_output("wrap_accepts", 32'(n), 32'd17);
    check_output("wrap_byte_count", 32'(byte_count2), 32'd1);

    check_output("final_queue", 32'(exp_q.size()), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
